// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY0 = 3'd1,
    BUSY1 = 3'd2,
    ACK0  = 3'd3,
    ACK1  = 3'd4
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not served last.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;

  always_comb begin
    grant = PORT_CPU;
    if (req0 && req1) begin
      grant = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (req1) begin
      grant = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a DMA requester onto one memory port, one access at a time,
// with a per-access wait timeout that completes the access with an error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q;
  logic          last_grant_q;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          pick_grant;
  logic          pick_valid;
  logic          busy;

  rr_pick u_rr_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign wait_d = wait_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DMA;
      wait_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            last_grant_q <= pick_grant;
            wait_q       <= '0;
            // The memory-side address/data registers double as the request latch.
            if (pick_grant == PORT_DMA) begin
              state_q <= BUSY1;
              we_q    <= we1;
              addr_q  <= addr1;
              wdata_q <= wdata1;
            end else begin
              state_q <= BUSY0;
              we_q    <= we0;
              addr_q  <= addr0;
              wdata_q <= wdata0;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (mem_ready) begin
            if (!we_q) rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            state_q <= (state_q == BUSY0) ? ACK0 : ACK1;
          end else if (wait_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= (state_q == BUSY0) ? ACK0 : ACK1;
          end else begin
            wait_q <= wait_d;
          end
        end
        ACK0, ACK1: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == BUSY0) || (state_q == BUSY1);
  assign mem_en    = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack0      = (state_q == ACK0);
  assign ack1      = (state_q == ACK1);
  assign err0      = (state_q == ACK0) && err_q;
  assign err1      = (state_q == ACK1) && err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_ack_cyc;

  // Reference model state
  logic          m_last;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_rdata = '0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  // One access: drive requests in an idle cycle, answer with ready after 'delay'
  // stalled cycles (delay >= TIMEOUT means ready never comes), check every cycle.
  task automatic txn(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input int delay, input logic [DW-1:0] rd_val, input bit chk_gap);
    logic          g, ew, tmo;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            nbusy;
    @(negedge clk);
    chk("idle_mem_en", mem_en, 1'b0);
    chk("idle_mem_addr_hold", mem_addr, m_addr);
    chk("idle_mem_wdata_hold", mem_wdata, m_wdata);
    chk("idle_acks", {ack0, ack1}, 2'b00);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    mem_ready = 1'b0;
    g      = (r0 && r1) ? ~m_last : r1;
    m_last = g;
    ew     = g ? w1 : w0;
    ea     = g ? a1 : a0;
    ed     = g ? d1 : d0;
    m_addr = ea; m_wdata = ed;
    tmo    = (delay >= TIMEOUT);
    nbusy  = tmo ? TIMEOUT : delay + 1;
    for (int i = 0; i < nbusy; i++) begin
      @(negedge clk);
      chk("busy_mem_en", mem_en, 1'b1);
      chk("busy_mem_we", mem_we, ew);
      chk("busy_mem_addr", mem_addr, ea);
      chk("busy_mem_wdata", mem_wdata, ed);
      chk("busy_no_ack", {ack0, ack1}, 2'b00);
      mem_ready = (i == delay);
      mem_rdata = (i == delay) ? rd_val : DW'($urandom);
      if (i == delay && !ew) m_rdata = rd_val;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = DW'($urandom);
    chk("ack_vec", {ack0, ack1}, g ? 2'b01 : 2'b10);
    chk("err_vec", {err0, err1}, g ? {1'b0, tmo} : {tmo, 1'b0});
    chk("ack_mem_en", mem_en, 1'b0);
    chk("ack_rdata", rdata, m_rdata);
    if (chk_gap) chk("ack_spacing", cyc - last_ack_cyc, 3);
    last_ack_cyc = cyc;
  endtask

  initial begin
    logic r0, r1;
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    last_ack_cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_outputs", {ack0, ack1, err0, err1, mem_en, mem_we}, 6'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_mem_addr", mem_addr, '0);
    reset = 1'b1;

    // CPU read, immediate ready
    txn(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0);
    req0 = 0;
    // DMA write with three stalled cycles
    txn(0, 1, 0, 1, 32'h0, 32'h40, 32'h0, 32'h12345678, 3, 32'hCAFEF00D, 0);
    req1 = 0;
    // CPU read that never gets ready: timeout
    txn(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 32'h0, 1000, 32'h0, 0);
    req0 = 0;

    // Stray ready pulse while idle must not start anything
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("stray_ready_mem_en", mem_en, 1'b0);
    chk("stray_ready_acks", {ack0, ack1}, 2'b00);
    @(negedge clk);
    chk("stray_ready_acks2", {ack0, ack1}, 2'b00);

    // Both held: strict alternation, acks three cycles apart
    for (int k = 0; k < 6; k++)
      txn(1, 1, 0, 0, 32'h1000 + k, 32'h2000 + k, 32'h0, 32'h0, 0, DW'($urandom), k > 0);
    req0 = 0; req1 = 0;

    // Randomized accesses
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      txn(r0, r1, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
          DW'($urandom), DW'($urandom),
          ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : int'($urandom_range(0, 6)),
          DW'($urandom), 0);
      if ($urandom_range(0, 1) == 1) begin req0 = 0; req1 = 0; end
    end
    req0 = 0; req1 = 0;

    // Reset in the middle of a DMA access
    @(negedge clk);
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 32'h55; wdata1 = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", mem_en, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_outputs", {ack0, ack1, err0, err1, mem_en, mem_we}, 6'b0);
    chk("midrst_rdata", rdata, '0);
    chk("midrst_mem_addr", mem_addr, '0);
    @(negedge clk);
    chk("midrst_no_ack", {ack0, ack1}, 2'b00);
    req1 = 0;
    model_reset();
    reset = 1'b1;
    txn(1, 1, 0, 0, 32'h300, 32'h400, 32'h0, 32'h0, 0, 32'hA5A5A5A5, 0);
    txn(1, 1, 1, 1, 32'h301, 32'h401, 32'h11, 32'h22, 2, 32'h0, 0);
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum memory wait cycles per access before error completion.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0/req1  in  1  request, port 0 = CPU, port 1 = DMA.
REQ-007 SHALL have ports we0/we1  in  1  write enable of the matching request.
REQ-008 SHALL have ports addr0/addr1  in  AW  and wdata0/wdata1  in  DW  request address and write data.
REQ-009 SHALL have ports ack0/ack1  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1  out  1  valid with ack; high means timeout.
REQ-011 SHALL have port rdata  out  DW  registered read data; valid in the ack cycle.
REQ-012 SHALL have ports mem_en, mem_we  out  1  and mem_addr  out  AW, mem_wdata  out  DW  shared memory port.
REQ-013 SHALL have ports mem_rdata  in  DW  and mem_ready  in  1  memory response.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY0, BUSY1, ACK0, ACK1.
REQ-015 IDLE: only req0 -> BUSY0; only req1 -> BUSY1; both -> port that is not last_grant; neither -> IDLE.
REQ-016 last_grant SHALL update to the granted port on each IDLE->BUSYx transition.
REQ-017 In BUSYx, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the values latched from port x at grant.
REQ-018 Outside BUSYx, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-019 In BUSYx with mem_ready=1: rdata <= mem_rdata (reads only; writes leave rdata unchanged), errx <= 0, next state ACKx.
REQ-020 A wait counter SHALL clear on grant and increment each BUSY cycle with mem_ready=0; on reaching TIMEOUT-1 with mem_ready=0, next state ACKx with errx=1 and rdata unchanged.
REQ-021 ACKx SHALL last exactly one cycle with ackx=1, then return to IDLE unconditionally.
REQ-022 Minimum latency: req sampled in IDLE at edge N -> BUSY at N+1 -> ack high N+2..N+3 -> IDLE at N+3.
REQ-023 Requesters SHALL hold req/we/addr/wdata until ack; req changes during BUSY/ACK SHALL be ignored.
REQ-024 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle; at most one access is outstanding.
REQ-026 A mem_ready pulse outside BUSYx SHALL be ignored.

Reset
REQ-027 Reset low SHALL immediately force state IDLE, last_grant = port 1 (CPU wins first tie), wait counter 0.
REQ-028 During reset, all outputs SHALL be 0, rdata included.
REQ-029 Reset asserted mid-BUSY SHALL abandon the access with no ack; after release the arbiter SHALL accept requests from the first clk edge.

Structure
REQ-030 Shared package mem_arb_pkg SHALL hold the state enum and the port-index constants PORT_CPU=0, PORT_DMA=1.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs req0, req1, last_grant; output grant index, valid); the FSM and counter stay in mem_arbiter.

Verification
REQ-032 CPU read, mem_ready tied 1, addr0=0x100, mem_rdata=0xDEADBEEF -> mem_en for 1 cycle, ack0 two cycles after req, rdata=0xDEADBEEF, err0=0.
REQ-033 req0 and req1 both held continuously, mem_ready=1 -> grants alternate CPU, DMA, CPU, DMA; each ack 3 cycles apart.
REQ-034 DMA write, addr1=0x40, wdata1=0x12345678, mem_ready low 3 cycles -> mem_en/mem_we high 4 cycles with those values, then single ack1, rdata unchanged.
REQ-035 CPU read with mem_ready stuck 0, TIMEOUT=16 -> mem_en high exactly 16 cycles, then ack0=1 and err0=1, FSM back to IDLE.
REQ-036 Reset low during BUSY1 -> outputs 0 within the same cycle, no ack1; after release, simultaneous req0/req1 -> CPU granted first.
